lap_playback: RTL
=================

Name: lap_playback

Overview:
- Read-side counterpart to the stopwatch lap store path.
- The store path writes `watch_data` snapshots into the 16x32 block RAM. This block reads them back in sequence, entry 0 to count-1, and presents each for a fixed number of tick pulses.
- It drives the memory address/enable and feeds the 32-bit display mux.
- It compensates for the RAM read latency, and supports single-pass and looped playback.

Parameters:
- ADDR_W, 4, memory address width; capacity 2^ADDR_W entries.
- DATA_W, 32, lap record width.
- RD_LAT, 1, memory read latency in cycles (legal 1..3).
- HOLD_TICKS, 100, tick pulses each entry stays on `data`.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins playback.
- stop  in  1  one-cycle pulse; aborts playback.
- loop  in  1  1 = wrap to entry 0 after the last entry; sampled on start.
- tick  in  1  one-cycle enable pulse (clock-divider terminal count).
- count  in  ADDR_W+1  number of valid stored entries; sampled on start.
- mem_en  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory read address.
- mem_data  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en.
- data  out  DATA_W  currently presented lap record.
- data_valid  out  1  `data` holds a record read in the current or last playback.
- index  out  ADDR_W  address of the record on `data`.
- busy  out  1  playback in progress (state != IDLE).
- done  out  1  one-cycle pulse at playback end (normal or count==0).

Behaviour:
- Reset (reset==0 at an edge) has priority over all inputs.
  - Outputs: data=0, data_valid=0, index=0, mem_en=0, mem_addr=0, busy=0, done=0.
  - State goes to IDLE; all counters are cleared.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE, start=1:
  - Latch cnt=min(count, 2^ADDR_W) and loop_r=loop.
  - Clear data_valid.
  - If cnt==0: done=1 next cycle, stay IDLE, no memory access.
  - Otherwise go to REQ with addr=0.
- REQ (1 cycle): mem_en=1, mem_addr=addr. Go to WAIT. mem_en is 0 in every other state.
- WAIT: lasts RD_LAT cycles.
  - At the edge ending the last WAIT cycle: data<=mem_data, index<=addr, data_valid<=1. Go to HOLD.
  - Latency: REQ at cycle t means data updates at the edge ending cycle t+RD_LAT.
- HOLD: hold counter increments on each tick. Ticks in REQ/WAIT are ignored and not accumulated.
- At the HOLD_TICKS-th tick:
  - If addr<cnt-1: addr<=addr+1, go to REQ.
  - Else if loop_r: addr<=0, go to REQ (wrap).
  - Else: done=1 for one cycle, go to IDLE.
- After normal completion, data/index/data_valid keep the last record.
- stop=1 in any non-IDLE state:
  - Go to IDLE the next cycle, clear data_valid, no done pulse.
  - A pending read is discarded: data is not updated.
- start and stop in the same cycle: stop wins; start is ignored.
- start while busy: ignored, no restart.
- count changes during playback: ignored (the latched cnt is used).
- mem_addr width: addr counts 0..cnt-1 and never exceeds 2^ADDR_W-1. No address overflow is possible.
- done and mem_en are registered outputs. busy is combinational from state.

Decomposition:
- Shared package `stopwatch_pkg`:
  - state enum (IDLE/REQ/WAIT/HOLD);
  - default ADDR_W=4, DATA_W=32 constants;
  - RD_LAT default, matched to the block RAM configuration.
- One natural sub-module, `tick_hold_counter`:
  - counts tick pulses up to HOLD_TICKS;
  - has sync clear;
  - emits an `expire` pulse.
- The FSM, address register, latency counter and capture register stay in `lap_playback`.

Test Plan:
- RAM model (RD_LAT=1) holds 0x11,0x22,0x33; HOLD_TICKS=2, count=3, loop=0; start, then tick every 5 cycles.
  - mem_en pulses at addr 0,1,2.
  - data shows 0x11, 0x22, 0x33, each for exactly 2 ticks.
  - data updates 1 cycle after each mem_en.
  - done pulses once; busy falls; data stays 0x33 with data_valid=1.
- count=0, start -> done=1 the next cycle; mem_en never asserted; busy stays 0; data_valid=0.
- Same setup with loop=1, run 8 entry periods -> index sequence 0,1,2,0,1,2,0,1; done never pulses. Then stop -> IDLE next cycle, data_valid=0, no done.
- stop asserted in the WAIT cycle after reading addr 1 -> data keeps 0x11, data_valid=0, no done, busy=0.
- start and stop in the same cycle from IDLE -> no mem_en, busy=0. start pulsed again mid-HOLD -> ignored, sequence undisturbed.
- reset low mid-HOLD at index 1 -> next cycle all outputs zero, state IDLE. A tick after reset has no effect until start.
- RD_LAT=3 variant -> data updates exactly 3 cycles after each mem_en; ticks during WAIT do not shorten HOLD.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: lap-store geometry, RAM latency and the
// playback FSM state encoding.
package stopwatch_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 32;
   // Block RAM is configured with a registered output only.
   localparam int RD_LAT_DEF = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } pb_state_e;

endpackage

// File: rtl/tick_hold_counter.sv
// Counts tick pulses while enabled; pulses expire on the HOLD_TICKS-th tick
// and restarts from zero. clear holds the count at zero.
module tick_hold_counter #(
   parameter int HOLD_TICKS = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expire
);

   localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   logic [CW-1:0] cnt;

   assign expire = !clear && tick && (cnt == CW'(HOLD_TICKS - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear || expire) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lap_playback.sv
// Reads stored lap records 0..cnt-1 back out of the lap RAM and presents each
// on data for HOLD_TICKS tick pulses, optionally looping.
module lap_playback
   import stopwatch_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int HOLD_TICKS = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop,
   input  logic              tick,
   input  logic [ADDR_W:0]   count,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   output logic [ADDR_W-1:0] index,
   output logic              busy,
   output logic              done,
   output pb_state_e         dbg_state
);

   // Control handshake: start and stop are single-cycle request pulses with no
   // acknowledge; stop wins over start, start is only honoured in IDLE, and
   // done is a single-cycle completion strobe registered one cycle later.

   localparam int              CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CAP  = {1'b1, {ADDR_W{1'b0}}};

   pb_state_e         state, state_next;
   logic [ADDR_W-1:0] addr, addr_d;
   logic [CNT_W-1:0]  cnt;
   logic              loop_r;
   logic [1:0]        lat_cnt;
   logic              expire, last, lat_done;
   logic              abort, pb_start, capture, advance, end_pulse;

   tick_hold_counter #(.HOLD_TICKS(HOLD_TICKS)) u_hold (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != HOLD),
      .tick   (tick),
      .expire (expire)
   );

   assign last      = ({1'b0, addr} == (cnt - 1'b1));
   assign lat_done  = (lat_cnt == 2'(RD_LAT - 1));
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start && !stop && (count != '0)) state_next = REQ;
         REQ:  state_next = stop ? IDLE : WAIT;
         WAIT: begin
            if (stop)          state_next = IDLE;
            else if (lat_done) state_next = HOLD;
         end
         HOLD: begin
            if (stop)                    state_next = IDLE;
            else if (expire && !last)    state_next = REQ;
            else if (expire && loop_r)   state_next = REQ;
            else if (expire)             state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      abort     = busy && stop;
      pb_start  = (state == IDLE) && start && !stop;
      capture   = (state == WAIT) && lat_done && !stop;
      advance   = (state == HOLD) && expire && !stop;
      end_pulse = advance && last && !loop_r;
      addr_d    = addr;
      if (pb_start)     addr_d = '0;
      else if (advance) addr_d = last ? '0 : addr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         addr       <= '0;
         cnt        <= '0;
         loop_r     <= 1'b0;
         lat_cnt    <= '0;
         done       <= 1'b0;
         data       <= '0;
         index      <= '0;
         data_valid <= 1'b0;
      end else begin
         mem_en   <= (state_next == REQ);
         mem_addr <= addr_d;
         addr     <= addr_d;
         done     <= end_pulse || (pb_start && (count == '0));
         lat_cnt  <= (state == WAIT) ? lat_cnt + 2'd1 : 2'd0;
         if (pb_start) begin
            cnt    <= (count > CAP) ? CAP : count;
            loop_r <= loop;
         end
         // A read in flight when stop arrives is dropped, never captured.
         if (pb_start || abort) data_valid <= 1'b0;
         else if (capture)      data_valid <= 1'b1;
         if (capture) begin
            data  <= mem_data;
            index <= addr;
         end
      end
   end

endmodule
